uart_tx_fifo: RTL and testbench

Hardware UART transmitter with a byte FIFO. It replaces the software bit-banged TX bit in the board wrapper. It sits directly downstream of the wrapper's registered bus stage: it consumes the registered write strobe and data for the TX address, serialises bytes 8N1 onto the uart_tx pin, and exposes FIFO and line status for the mapped read mux.

---
 rtl/uart_tx_fifo.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a byte FIFO; consumes registered bus write strobes
// and reports FIFO occupancy, full/empty and a sticky overflow flag.
module uart_tx_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_en,
   input  logic [7:0]           wr_data,
   input  logic [DIV_WIDTH-1:0] bit_width,
   input  logic                 clr_overflow,
   output logic                 tx,
   output logic                 busy,
   output logic                 fifo_empty,
   output logic                 fifo_full,
   output logic [DEPTH_LOG2:0]  level,
   output logic                 overflow
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam int unsigned LW    = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                state;
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [7:0]            shift;
   logic [2:0]            idx;
   logic [DIV_WIDTH-1:0]  bw;
   logic [DIV_WIDTH-1:0]  cnt;

   logic                  push_c;
   logic                  pop_c;
   logic                  drop_c;
   logic [LW-1:0]         level_next_c;
   logic [DIV_WIDTH-1:0]  bw_in_c;

   // A pop only ever sees the registered empty flag, so a byte pushed this edge waits one cycle.
   always_comb begin
      push_c       = wr_en && !fifo_full;
      drop_c       = wr_en && fifo_full;
      pop_c        = !fifo_empty && ((state == IDLE) || ((state == STOP) && (cnt == '0)));
      bw_in_c      = (bit_width == '0) ? DIV_WIDTH'(1) : bit_width;
      level_next_c = level;
      if (push_c && !pop_c) begin
         level_next_c = level + LW'(1);
      end else if (pop_c && !push_c) begin
         level_next_c = level - LW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_c && !rst) begin
         mem[wptr] <= wr_data;
      end
   end

   // Pointers, occupancy and status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         level      <= '0;
         fifo_empty <= 1'b1;
         fifo_full  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (push_c) begin
            wptr <= wptr + DEPTH_LOG2'(1);
         end
         if (pop_c) begin
            rptr <= rptr + DEPTH_LOG2'(1);
         end
         level      <= level_next_c;
         fifo_empty <= (level_next_c == '0);
         fifo_full  <= (level_next_c == LW'(DEPTH));
         if (drop_c) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   // Frame sequencer; tx and busy are set on the edge that enters each state or bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         tx    <= 1'b1;
         busy  <= 1'b0;
         shift <= '0;
         idx   <= '0;
         bw    <= DIV_WIDTH'(1);
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pop_c) begin
                  shift <= mem[rptr];
                  bw    <= bw_in_c;
                  cnt   <= bw_in_c - DIV_WIDTH'(1);
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (cnt == '0) begin
                  cnt   <= bw - DIV_WIDTH'(1);
                  idx   <= '0;
                  state <= DATA;
                  tx    <= shift[0];
               end else begin
                  cnt <= cnt - DIV_WIDTH'(1);
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  cnt <= bw - DIV_WIDTH'(1);
                  if (idx == 3'd7) begin
                     state <= STOP;
                     tx    <= 1'b1;
                  end else begin
                     shift <= shift >> 1;
                     idx   <= idx + 3'd1;
                     tx    <= shift[1];
                  end
               end else begin
                  cnt <= cnt - DIV_WIDTH'(1);
               end
            end
            STOP: begin
               if (cnt == '0) begin
                  if (pop_c) begin
                     shift <= mem[rptr];
                     bw    <= bw_in_c;
                     cnt   <= bw_in_c - DIV_WIDTH'(1);
                     state <= START;
                     tx    <= 1'b0;
                  end else begin
                     state <= IDLE;
                     tx    <= 1'b1;
                     busy  <= 1'b0;
                  end
               end else begin
                  cnt <= cnt - DIV_WIDTH'(1);
               end
            end
            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based line model compared every cycle, plus
// literal waveform checks for the directed scenarios and a randomized phase.
module tb_uart_tx_fifo;

   localparam int unsigned DL    = 2;
   localparam int unsigned DW    = 16;
   localparam int unsigned DEPTH = 1 << DL;
   localparam int unsigned HN    = 32768;

   logic          clk;
   logic          rst;
   logic          wr_en;
   logic [7:0]    wr_data;
   logic [DW-1:0] bit_width;
   logic          clr_overflow;
   logic          tx;
   logic          busy;
   logic          fifo_empty;
   logic          fifo_full;
   logic [DL:0]   level;
   logic          overflow;

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(.DEPTH_LOG2(DL), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
      .bit_width(bit_width), .clr_overflow(clr_overflow), .tx(tx), .busy(busy),
      .fifo_empty(fifo_empty), .fifo_full(fifo_full), .level(level), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: FIFO as a queue of bytes, the line as a queue of per-cycle tx values.
   logic [7:0] q[$];
   bit         line[$];
   bit         m_tx, m_busy, m_ovf, m_valid;
   int         n0, bwm;
   logic [7:0] b;
   bit         v;

   initial begin
      m_valid = 0; m_tx = 1; m_busy = 0; m_ovf = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         q.delete(); line.delete();
         m_tx = 1; m_busy = 0; m_ovf = 0; m_valid = 1;
      end else if (m_valid) begin
         n0 = q.size();
         if (line.size() == 0 && n0 > 0) begin
            b   = q.pop_front();
            bwm = (bit_width == 0) ? 1 : int'(bit_width);
            for (int k = 0; k < 10; k++) begin
               v = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
               for (int r = 0; r < bwm; r++) line.push_back(v);
            end
         end
         if (line.size() > 0) begin
            m_tx = line.pop_front(); m_busy = 1;
         end else begin
            m_tx = 1; m_busy = 0;
         end
         if (wr_en && n0 < DEPTH) q.push_back(wr_data);
         if (wr_en && n0 == DEPTH) m_ovf = 1;
         else if (clr_overflow) m_ovf = 0;
      end
   end

   // Compare process plus per-cycle history for the literal waveform checks.
   int   cyc = 0;
   logic hist_tx   [HN];
   logic hist_busy [HN];
   logic [DL:0] hist_lvl [HN];

   always @(negedge clk) begin
      cyc++;
      hist_tx[cyc % HN]   = tx;
      hist_busy[cyc % HN] = busy;
      hist_lvl[cyc % HN]  = level;
      if (m_valid) begin
         check("tx", 32'(tx), 32'(m_tx));
         check("busy", 32'(busy), 32'(m_busy));
         check("level", 32'(level), 32'(q.size()));
         check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
         check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
         check("overflow", 32'(overflow), 32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [7:0] d);
      wr_en = 1'b1; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   int         wcyc, base, zeros;
   logic [9:0] pat, frm, exp_frm;
   logic [7:0] bytes3 [3];

   initial begin
      rst = 1'b1; wr_en = 1'b0; wr_data = '0; bit_width = DW'(4); clr_overflow = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Idle after reset
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("idle_tx", 32'(tx), 32'd1);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_empty", 32'(fifo_empty), 32'd1);
         check("idle_level", 32'(level), 32'd0);
         check("idle_ovf", 32'(overflow), 32'd0);
      end
      tick();

      // 0x55 at bw=4
      bit_width = DW'(4);
      write(8'h55);
      wcyc = cyc + 1;
      repeat (50) tick();
      pat = 10'b1010101010;
      check("x55_pre", 32'(hist_tx[wcyc % HN]), 32'd1);
      for (int i = 0; i < 40; i++)
         check("x55_bit", 32'(hist_tx[(wcyc + 1 + i) % HN]), 32'(pat[i / 4]));
      check("x55_busy_last", 32'(hist_busy[(wcyc + 40) % HN]), 32'd1);
      check("x55_busy_fall", 32'(hist_busy[(wcyc + 41) % HN]), 32'd0);

      // Three back-to-back frames at bw=3
      bit_width = DW'(3);
      bytes3[0] = 8'hA5; bytes3[1] = 8'h0F; bytes3[2] = 8'hFF;
      wr_en = 1'b1; wr_data = bytes3[0]; tick();
      wcyc = cyc + 1;
      wr_data = bytes3[1]; tick();
      wr_data = bytes3[2]; tick();
      wr_en = 1'b0;
      repeat (100) tick();
      check("b2b_lvl0", 32'(hist_lvl[wcyc % HN]), 32'd1);
      check("b2b_lvl1", 32'(hist_lvl[(wcyc + 1) % HN]), 32'd1);
      check("b2b_lvl2", 32'(hist_lvl[(wcyc + 2) % HN]), 32'd2);
      for (int k = 0; k < 3; k++) begin
         base = wcyc + 1 + 30 * k;
         for (int j = 0; j < 10; j++) frm[j] = hist_tx[(base + 3 * j + 1) % HN];
         exp_frm = {1'b1, bytes3[k], 1'b0};
         check("b2b_frame", 32'(frm), 32'(exp_frm));
         check("b2b_start_edge", 32'(hist_tx[base % HN]), 32'd0);
      end
      zeros = 0;
      for (int i = 1; i <= 90; i++) if (hist_busy[(wcyc + i) % HN] == 1'b0) zeros++;
      check("b2b_no_gap", 32'(zeros), 32'd0);
      check("b2b_busy_fall", 32'(hist_busy[(wcyc + 91) % HN]), 32'd0);

      // Overflow with a 4-deep FIFO
      bit_width = DW'(100);
      wr_en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         wr_data = 8'(i); tick();
      end
      wr_en = 1'b0;
      @(negedge clk);
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_full", 32'(fifo_full), 32'd1);
      check("ovf_flag", 32'(overflow), 32'd1);
      clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
      @(negedge clk);
      check("ovf_clear", 32'(overflow), 32'd0);
      repeat (5 * 1000 + 20) tick();
      @(negedge clk);
      check("ovf_drained", 32'(busy), 32'd0);

      // Zero divisor behaves as one
      bit_width = '0;
      write(8'h81);
      wcyc = cyc + 1;
      repeat (15) tick();
      pat = 10'b1100000010;
      for (int i = 0; i < 10; i++)
         check("x81_bit", 32'(hist_tx[(wcyc + 1 + i) % HN]), 32'(pat[i]));
      check("x81_busy_fall", 32'(hist_busy[(wcyc + 11) % HN]), 32'd0);

      // Reset in the middle of a frame with bytes queued
      bit_width = DW'(8);
      wr_en = 1'b1;
      wr_data = 8'h3C; tick();
      wr_data = 8'hC3; tick();
      wr_data = 8'h5A; tick();
      wr_en = 1'b0;
      repeat (20) tick();
      rst = 1'b1; tick(); rst = 1'b0;
      @(negedge clk);
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("rst_quiet", 32'({tx, busy}), 32'b10);
      end
      tick();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         wr_en        = ($urandom_range(0, 3) == 0);
         wr_data      = 8'($urandom);
         clr_overflow = ($urandom_range(0, 15) == 0);
         rst          = ($urandom_range(0, 699) == 0);
         if ($urandom_range(0, 49) == 0) bit_width = DW'($urandom_range(0, 3));
         tick();
      end
      wr_en = 1'b0; clr_overflow = 1'b0; rst = 1'b0;
      repeat (200) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
